// File: rtl/afifo_wr_arbiter_pkg.sv
// Shared types and helpers for the async-FIFO write arbiter.
// State encoding and a width helper used by the top and rr_pick.
package afifo_wr_arbiter_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    BURST = 1'b1
  } state_t;

  // Index width for n items, never below one bit.
  function automatic int clog2(input int n);
    int r;
    r = 0;
    for (int v = n - 1; v > 0; v = v >> 1) begin
      r++;
    end
    if (r == 0) begin
      r = 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/afifo_wr_arbiter_rr_pick.sv
// Round-robin priority search: first set req bit at or above rr_ptr,
// wrapping modulo N. Purely combinational.
module rr_pick
  import afifo_wr_arbiter_pkg::*;
#(
  parameter int N = 4,
  parameter int W = clog2(N)
) (
  input  logic [N-1:0] req,
  input  logic [W-1:0] rr_ptr,
  output logic         valid,
  output logic [W-1:0] index
);

  // Walk from farthest to nearest so the nearest hit wins.
  always_comb begin
    valid = 1'b0;
    index = '0;
    for (int k = N - 1; k >= 0; k--) begin
      if (req[(int'(rr_ptr) + k) % N]) begin
        valid = 1'b1;
        index = W'((int'(rr_ptr) + k) % N);
      end
    end
  end

endmodule

// File: rtl/afifo_wr_arbiter.sv
// Round-robin burst arbiter feeding the write side of an async FIFO.
// One arbitration cycle per grant, then beats until last/limit/withdraw.
module afifo_wr_arbiter
  import afifo_wr_arbiter_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int NUM_REQ    = 4,
  parameter int MAX_BURST  = 8
) (
  input  logic                          CLK,
  input  logic                          RST,
  input  logic [NUM_REQ-1:0]            req,
  input  logic [NUM_REQ-1:0]            req_last,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
  output logic [NUM_REQ-1:0]            ack,
  output logic                          fifo_enq,
  output logic [DATA_WIDTH-1:0]         fifo_data,
  input  logic                          fifo_full,
  output logic [clog2(NUM_REQ)-1:0]     owner,
  output logic                          busy
);

  localparam int IW = clog2(NUM_REQ);
  localparam int CW = clog2(MAX_BURST);

  state_t          state;
  state_t          state_n;
  logic [IW-1:0]   owner_n;
  logic [IW-1:0]   rr_ptr;
  logic [IW-1:0]   rr_ptr_n;
  logic [IW-1:0]   owner_inc;
  logic [CW-1:0]   beat_cnt;
  logic [CW-1:0]   beat_n;
  logic            pick_valid;
  logic [IW-1:0]   pick_idx;
  logic            go;
  logic            last_beat;

  rr_pick #(
    .N (NUM_REQ),
    .W (IW)
  ) u_pick (
    .req    (req),
    .rr_ptr (rr_ptr),
    .valid  (pick_valid),
    .index  (pick_idx)
  );

  // Reset masks the outputs in the same cycle, not just at the edge.
  assign go = (state == BURST) & req[owner]
            & ~fifo_full & ~RST;

  assign last_beat = req_last[owner]
                   | (beat_cnt == CW'(MAX_BURST - 1));

  assign owner_inc = (owner == IW'(NUM_REQ - 1))
                   ? '0 : owner + 1'b1;

  assign fifo_enq  = go;
  assign ack       = go ? (NUM_REQ'(1) << owner) : '0;
  assign busy      = (state == BURST) & ~RST;
  assign fifo_data =
    req_data[int'(owner)*DATA_WIDTH +: DATA_WIDTH];

  always_comb begin
    state_n  = state;
    owner_n  = owner;
    rr_ptr_n = rr_ptr;
    beat_n   = beat_cnt;
    unique case (state)
      IDLE: begin
        if (pick_valid) begin
          state_n = BURST;
          owner_n = pick_idx;
          beat_n  = '0;
        end
      end
      BURST: begin
        if (!req[owner] || (go && last_beat)) begin
          state_n  = IDLE;
          rr_ptr_n = owner_inc;
        end else if (go) begin
          beat_n = beat_cnt + 1'b1;
        end
      end
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state    <= IDLE;
      owner    <= '0;
      rr_ptr   <= '0;
      beat_cnt <= '0;
    end else begin
      state    <= state_n;
      owner    <= owner_n;
      rr_ptr   <= rr_ptr_n;
      beat_cnt <= beat_n;
    end
  end

endmodule

// File: tb/tb_afifo_wr_arbiter.sv
// Bench for afifo_wr_arbiter: directed scenarios plus random traffic,
// with a queue of expected FIFO writes drained by a monitor.
module tb_afifo_wr_arbiter;

  localparam int DW = 32;
  localparam int N  = 4;
  localparam int MB = 4;
  localparam int IW = 2;

  logic          CLK = 1'b0;
  logic          RST;
  logic [N-1:0]  req;
  logic [N-1:0]  req_last;
  logic [N*DW-1:0] req_data;
  logic [N-1:0]  ack;
  logic          fifo_enq;
  logic [DW-1:0] fifo_data;
  logic          fifo_full;
  logic [IW-1:0] owner;
  logic          busy;

  always #5 CLK = ~CLK;

  afifo_wr_arbiter #(
    .DATA_WIDTH (DW),
    .NUM_REQ    (N),
    .MAX_BURST  (MB)
  ) dut (
    .CLK       (CLK),
    .RST       (RST),
    .req       (req),
    .req_last  (req_last),
    .req_data  (req_data),
    .ack       (ack),
    .fifo_enq  (fifo_enq),
    .fifo_data (fifo_data),
    .fifo_full (fifo_full),
    .owner     (owner),
    .busy      (busy)
  );

  typedef struct {
    int          idx;
    logic [31:0] data;
  } beat_t;

  int    errors = 0;
  int    checks = 0;
  beat_t sb[$];
  int    grant_log[$];
  int    beat_log[$];

  // Requester sources
  int          rem[N];
  logic [DW-1:0] sdat[N];
  bit          nolast[N];
  bit          wd[N];
  bit          rst_cmd;
  bit          full_cmd;

  // Reference model
  bit       m_busy;
  int       m_own;
  int       m_ptr;
  int       m_cnt;
  logic [N-1:0] e_ack;
  bit       e_enq;
  bit       e_busy;

  logic          s_busy;
  logic          s_enq;
  logic [N-1:0]  s_ack;
  logic [IW-1:0] s_owner;
  logic [DW-1:0] s_data;

  task automatic chk(string name, logic [63:0] act,
                     logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h",
               name, act, exp);
    end
  endtask

  task automatic drive();
    RST       = rst_cmd;
    fifo_full = full_cmd;
    for (int i = 0; i < N; i++) begin
      req[i]      = rem[i] > 0;
      req_last[i] = (rem[i] == 1) && !nolast[i];
      req_data[i*DW +: DW] = sdat[i];
    end
  endtask

  task automatic model_update();
    bit fin;
    bit found;
    fin   = 1'b0;
    found = 1'b0;
    if (rst_cmd) begin
      m_busy = 1'b0;
      m_ptr  = 0;
      m_own  = 0;
      m_cnt  = 0;
    end else if (!m_busy) begin
      for (int k = 0; k < N; k++) begin
        if (!found && req[(m_ptr + k) % N]) begin
          found  = 1'b1;
          m_own  = (m_ptr + k) % N;
          m_busy = 1'b1;
          m_cnt  = 0;
        end
      end
    end else begin
      fin = !req[m_own];
      if (e_enq) begin
        m_cnt++;
        if (req_last[m_own] || m_cnt == MB) fin = 1'b1;
      end
      if (fin) begin
        m_busy = 1'b0;
        m_ptr  = (m_own + 1) % N;
      end
    end
  endtask

  task automatic src_update();
    for (int i = 0; i < N; i++) begin
      if (e_ack[i]) begin
        sdat[i] = sdat[i] + 1;
        if (wd[i]) begin
          rem[i] = 0;
          wd[i]  = 1'b0;
        end else begin
          rem[i] = rem[i] - 1;
        end
      end
    end
  endtask

  task automatic step();
    drive();
    e_ack  = '0;
    e_enq  = 1'b0;
    e_busy = m_busy && !rst_cmd;
    if (e_busy && req[m_own] && !full_cmd) begin
      e_enq        = 1'b1;
      e_ack[m_own] = 1'b1;
      sb.push_back('{m_own, sdat[m_own]});
    end
    @(negedge CLK);
    s_busy  = busy;
    s_enq   = fifo_enq;
    s_ack   = ack;
    s_owner = owner;
    s_data  = fifo_data;
    chk("busy", busy, e_busy);
    chk("enq", fifo_enq, e_enq);
    chk("ack", ack, e_ack);
    if (e_busy) chk("owner", owner, m_own);
    @(posedge CLK);
    model_update();
    src_update();
    #1;
  endtask

  task automatic clear_src();
    for (int i = 0; i < N; i++) begin
      rem[i]    = 0;
      nolast[i] = 1'b0;
      wd[i]     = 1'b0;
    end
  endtask

  task automatic do_reset();
    clear_src();
    rst_cmd = 1'b1;
    step();
    rst_cmd = 1'b0;
  endtask

  function automatic int log_at(int q[$], int k);
    return (k < q.size()) ? q[k] : -1;
  endfunction

  // Monitor: scoreboard pops, bus invariants, grant log
  initial begin
    int    cnt;
    logic  pb;
    beat_t b;
    cnt = 0;
    pb  = 1'b0;
    forever begin
      @(negedge CLK);
      chk("enq_while_full", fifo_enq & fifo_full, 0);
      chk("ack_onehot", $countones(ack) <= 1, 1);
      if (fifo_enq) begin
        if (sb.size() == 0) begin
          chk("sb_unexpected_enq", fifo_enq, 0);
        end else begin
          b = sb.pop_front();
          chk("sb_data", fifo_data, b.data);
          chk("sb_ack", ack, N'(1) << b.idx);
        end
      end
      if (busy && !pb) begin
        grant_log.push_back(int'(owner));
        cnt = 0;
      end
      if (busy && fifo_enq) cnt++;
      if (!busy && pb) beat_log.push_back(cnt);
      pb = busy;
    end
  end

  initial begin
    int e1[4] = '{2, 3, 0, 1};
    int e2[5] = '{0, 1, 2, 3, 0};
    rst_cmd  = 1'b1;
    full_cmd = 1'b0;
    m_busy   = 1'b0;
    m_own    = 0;
    m_ptr    = 0;
    m_cnt    = 0;
    clear_src();
    for (int i = 0; i < N; i++) sdat[i] = '0;
    drive();
    @(posedge CLK);
    #1;
    repeat (3) step();
    chk("rst_busy", s_busy, 0);
    chk("rst_enq", s_enq, 0);
    chk("rst_ack", s_ack, 0);
    rst_cmd = 1'b0;

    // Single requester, four-beat burst
    rem[1]  = 4;
    sdat[1] = 32'hA0;
    step();
    chk("t1_arb_busy", s_busy, 0);
    for (int k = 0; k < 4; k++) begin
      step();
      chk("t1_busy", s_busy, 1);
      chk("t1_enq", s_enq, 1);
      chk("t1_owner", s_owner, 1);
      chk("t1_data", s_data, 32'hA0 + k);
    end
    step();
    chk("t1_idle", s_busy, 0);
    grant_log.delete();
    for (int i = 0; i < N; i++) begin
      rem[i]  = 1;
      sdat[i] = 32'h100 * (i + 1);
    end
    repeat (10) step();
    for (int k = 0; k < 4; k++)
      chk($sformatf("t1_rr%0d", k),
          log_at(grant_log, k), e1[k]);

    // Fairness with all requesters held
    do_reset();
    grant_log.delete();
    beat_log.delete();
    for (int i = 0; i < N; i++) begin
      rem[i]    = 1000;
      nolast[i] = 1'b1;
      sdat[i]   = 32'h1000 * (i + 1);
    end
    repeat (26) step();
    for (int k = 0; k < 5; k++)
      chk($sformatf("t2_grant%0d", k),
          log_at(grant_log, k), e2[k]);
    for (int k = 0; k < 4; k++)
      chk($sformatf("t2_beats%0d", k),
          log_at(beat_log, k), MB);

    // FIFO full stall in owner 2's burst
    do_reset();
    rem[2]    = 100;
    nolast[2] = 1'b1;
    sdat[2]   = 32'hC0;
    repeat (3) step();
    full_cmd = 1'b1;
    repeat (3) begin
      step();
      chk("t3_stall_enq", s_enq, 0);
      chk("t3_stall_ack", s_ack, 0);
      chk("t3_stall_owner", s_owner, 2);
      chk("t3_stall_busy", s_busy, 1);
    end
    full_cmd = 1'b0;
    step();
    chk("t3_data2", s_data, 32'hC2);
    step();
    chk("t3_data3", s_data, 32'hC3);
    chk("t3_enq3", s_enq, 1);
    clear_src();
    step();
    chk("t3_end", s_busy, 0);

    // Owner 0 withdraws after one beat
    do_reset();
    rem[0]  = 8;
    wd[0]   = 1'b1;
    sdat[0] = 32'hD0;
    step();
    step();
    chk("t4_beat", s_enq, 1);
    step();
    chk("t4_no_enq", s_enq, 0);
    step();
    chk("t4_idle", s_busy, 0);
    grant_log.delete();
    rem[0]  = 1;
    rem[1]  = 1;
    sdat[1] = 32'hB0;
    repeat (6) step();
    chk("t4_next", log_at(grant_log, 0), 1);

    // Reset during owner 3's third beat
    do_reset();
    rem[3]    = 100;
    nolast[3] = 1'b1;
    sdat[3]   = 32'hE0;
    repeat (3) step();
    rst_cmd = 1'b1;
    step();
    chk("t5_busy", s_busy, 0);
    chk("t5_enq", s_enq, 0);
    chk("t5_ack", s_ack, 0);
    rst_cmd = 1'b0;
    grant_log.delete();
    rem[1]  = 2;
    sdat[1] = 32'hF0;
    repeat (8) step();
    chk("t5_next", log_at(grant_log, 0), 1);

    // Random traffic
    do_reset();
    for (int c = 0; c < 3000; c++) begin
      for (int i = 0; i < N; i++) begin
        if (rem[i] == 0 && $urandom_range(0, 3) == 0) begin
          rem[i]    = $urandom_range(1, 7);
          nolast[i] = $urandom_range(0, 4) == 0;
          sdat[i]   = $urandom;
        end
      end
      full_cmd = $urandom_range(0, 3) == 0;
      rst_cmd  = $urandom_range(0, 299) == 0;
      step();
    end
    rst_cmd  = 1'b0;
    full_cmd = 1'b0;
    clear_src();
    repeat (4) step();
    chk("sb_empty", sb.size(), 0);
    $display("Result: errors=%0d of %0d checks",
             errors, checks);
    $finish;
  end

endmodule
